// File: rtl/cache_mem_arbiter.sv
// Two-to-one arbiter sharing the next-level memory port between the icache and dcache
// controllers, with a one-cycle lock after a write so write-back + allocate stay atomic.
module cache_mem_arbiter #(
  parameter int          ADDR_W     = 32,
  parameter int          LINE_W     = 128,
  parameter int          CNT_W      = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_req_valid_i,
  input  logic              ic_req_rw_i,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  input  logic [LINE_W-1:0] ic_req_data_i,
  output logic              ic_res_ready_o,
  output logic [LINE_W-1:0] ic_res_data_o,
  input  logic              dc_req_valid_i,
  input  logic              dc_req_rw_i,
  input  logic [ADDR_W-1:0] dc_req_addr_i,
  input  logic [LINE_W-1:0] dc_req_data_i,
  output logic              dc_res_ready_o,
  output logic [LINE_W-1:0] dc_res_data_o,
  output logic              mem_req_valid_o,
  output logic              mem_req_rw_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [LINE_W-1:0] mem_req_data_o,
  input  logic              mem_res_ready_i,
  input  logic [LINE_W-1:0] mem_res_data_i,
  output logic [1:0]        grant_o,
  output logic [CNT_W-1:0]  no_grant_ic_o,
  output logic [CNT_W-1:0]  no_grant_dc_o,
  output logic [CNT_W-1:0]  no_conflict_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GRANT_IC = 3'd1;
  localparam logic [2:0] GRANT_DC = 3'd2;
  localparam logic [2:0] LOCK_IC  = 3'd3;
  localparam logic [2:0] LOCK_DC  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             last_dc_q, last_dc_d;
  logic [CNT_W-1:0] cnt_ic_q, cnt_dc_q, cnt_cf_q;
  logic             inc_ic, inc_dc, inc_cf;
  logic             arb_en;
  logic             gnt_ic, gnt_dc;

  always_comb begin
    state_d   = state_q;
    last_dc_d = last_dc_q;
    inc_ic    = 1'b0;
    inc_dc    = 1'b0;
    inc_cf    = 1'b0;
    arb_en    = 1'b0;
    case (state_q)
      IDLE: arb_en = 1'b1;
      LOCK_IC: begin
        if (ic_req_valid_i) state_d = GRANT_IC;
        else                arb_en  = 1'b1;
      end
      LOCK_DC: begin
        if (dc_req_valid_i) state_d = GRANT_DC;
        else                arb_en  = 1'b1;
      end
      GRANT_IC: begin
        if (!ic_req_valid_i)      state_d = IDLE;
        else if (mem_res_ready_i) state_d = ic_req_rw_i ? LOCK_IC : IDLE;
      end
      GRANT_DC: begin
        if (!dc_req_valid_i)      state_d = IDLE;
        else if (mem_res_ready_i) state_d = dc_req_rw_i ? LOCK_DC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // On a tie the dcache wins if it has fixed priority or the icache was granted last.
    if (arb_en) begin
      state_d = IDLE;
      inc_cf  = ic_req_valid_i && dc_req_valid_i;
      if (dc_req_valid_i && (!ic_req_valid_i || FIXED_PRIO != 0 || !last_dc_q)) begin
        state_d   = GRANT_DC;
        inc_dc    = 1'b1;
        last_dc_d = 1'b1;
      end else if (ic_req_valid_i) begin
        state_d   = GRANT_IC;
        inc_ic    = 1'b1;
        last_dc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      last_dc_q <= 1'b0;
      cnt_ic_q  <= '0;
      cnt_dc_q  <= '0;
      cnt_cf_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_dc_q <= last_dc_d;
      if (inc_ic) cnt_ic_q <= cnt_ic_q + CNT_W'(1);
      if (inc_dc) cnt_dc_q <= cnt_dc_q + CNT_W'(1);
      if (inc_cf) cnt_cf_q <= cnt_cf_q + CNT_W'(1);
    end
  end

  assign gnt_ic = (state_q == GRANT_IC);
  assign gnt_dc = (state_q == GRANT_DC);

  assign grant_o         = {gnt_dc, gnt_ic};
  assign mem_req_valid_o = (gnt_ic && ic_req_valid_i) || (gnt_dc && dc_req_valid_i);
  assign mem_req_rw_o    = gnt_ic ? ic_req_rw_i   : (gnt_dc ? dc_req_rw_i   : 1'b0);
  assign mem_req_addr_o  = gnt_ic ? ic_req_addr_i : (gnt_dc ? dc_req_addr_i : '0);
  assign mem_req_data_o  = gnt_ic ? ic_req_data_i : (gnt_dc ? dc_req_data_i : '0);

  // A response only counts while the granted request is still held.
  assign ic_res_ready_o = gnt_ic && ic_req_valid_i && mem_res_ready_i;
  assign dc_res_ready_o = gnt_dc && dc_req_valid_i && mem_res_ready_i;
  assign ic_res_data_o  = mem_res_data_i;
  assign dc_res_data_o  = mem_res_data_i;

  assign no_grant_ic_o = cnt_ic_q;
  assign no_grant_dc_o = cnt_dc_q;
  assign no_conflict_o = cnt_cf_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus random traffic, two instances
// (round-robin with 32-bit counters, fixed-priority with 4-bit wrapping counters).
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int CW = 32;
  localparam int CWF = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic ic_v = 1'b0, ic_rw = 1'b0, dc_v = 1'b0, dc_rw = 1'b0, mr = 1'b0;
  logic [AW-1:0] ic_a = '0, dc_a = '0;
  logic [LW-1:0] ic_d = '0, dc_d = '0, md = '0;

  logic ic_rr0, dc_rr0, mv0, mrw0, ic_rr1, dc_rr1, mv1, mrw1;
  logic [LW-1:0] ic_rd0, dc_rd0, mdat0, ic_rd1, dc_rd1, mdat1;
  logic [AW-1:0] ma0, ma1;
  logic [1:0] g0, g1;
  logic [CW-1:0] nic0, ndc0, ncf0;
  logic [CWF-1:0] nic1, ndc1, ncf1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW), .FIXED_PRIO(0)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ic_req_valid_i(ic_v), .ic_req_rw_i(ic_rw), .ic_req_addr_i(ic_a), .ic_req_data_i(ic_d),
    .ic_res_ready_o(ic_rr0), .ic_res_data_o(ic_rd0),
    .dc_req_valid_i(dc_v), .dc_req_rw_i(dc_rw), .dc_req_addr_i(dc_a), .dc_req_data_i(dc_d),
    .dc_res_ready_o(dc_rr0), .dc_res_data_o(dc_rd0),
    .mem_req_valid_o(mv0), .mem_req_rw_o(mrw0), .mem_req_addr_o(ma0), .mem_req_data_o(mdat0),
    .mem_res_ready_i(mr), .mem_res_data_i(md), .grant_o(g0),
    .no_grant_ic_o(nic0), .no_grant_dc_o(ndc0), .no_conflict_o(ncf0));

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CWF), .FIXED_PRIO(1)) dut_fp (
    .clk_i(clk), .rst_ni(rst_ni),
    .ic_req_valid_i(ic_v), .ic_req_rw_i(ic_rw), .ic_req_addr_i(ic_a), .ic_req_data_i(ic_d),
    .ic_res_ready_o(ic_rr1), .ic_res_data_o(ic_rd1),
    .dc_req_valid_i(dc_v), .dc_req_rw_i(dc_rw), .dc_req_addr_i(dc_a), .dc_req_data_i(dc_d),
    .dc_res_ready_o(dc_rr1), .dc_res_data_o(dc_rd1),
    .mem_req_valid_o(mv1), .mem_req_rw_o(mrw1), .mem_req_addr_o(ma1), .mem_req_data_o(mdat1),
    .mem_res_ready_i(mr), .mem_res_data_i(md), .grant_o(g1),
    .no_grant_ic_o(nic1), .no_grant_dc_o(ndc1), .no_conflict_o(ncf1));

  // owner: 0 none, 1 icache, 2 dcache. lock_for: requester that may reclaim the port next cycle.
  typedef struct packed {
    logic [1:0]  owner;
    logic [1:0]  lock_for;
    logic        last_dc;
    logic [31:0] nic, ndc, ncf;
  } mst_t;

  typedef struct packed {
    logic        mv, mrw;
    logic [AW-1:0] ma;
    logic [LW-1:0] mdat;
    logic        icr, dcr;
    logic [LW-1:0] rdat;
    logic [1:0]  g;
    logic [31:0] nic, ndc, ncf;
  } exp_t;

  mst_t ms0, ms1, n0, n1;
  exp_t e0, e1;

  function automatic void model_step(input mst_t s, input bit fp, input logic [31:0] mask,
                                     output exp_t e, output mst_t n);
    logic v, rw;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    logic [1:0] pick;
    e = '0;
    n = s;
    e.rdat = md;
    e.nic = s.nic;
    e.ndc = s.ndc;
    e.ncf = s.ncf;
    if (s.owner != 2'd0) begin
      v  = (s.owner == 2'd1) ? ic_v  : dc_v;
      rw = (s.owner == 2'd1) ? ic_rw : dc_rw;
      a  = (s.owner == 2'd1) ? ic_a  : dc_a;
      d  = (s.owner == 2'd1) ? ic_d  : dc_d;
      e.g = (s.owner == 2'd1) ? 2'b01 : 2'b10;
      e.mv = v;
      e.mrw = rw;
      e.ma = a;
      e.mdat = d;
      if (v && mr) begin
        e.icr = (s.owner == 2'd1);
        e.dcr = (s.owner == 2'd2);
        n.owner = 2'd0;
        n.lock_for = rw ? s.owner : 2'd0;
      end else if (!v) begin
        n.owner = 2'd0;
        n.lock_for = 2'd0;
      end
    end else if ((s.lock_for == 2'd1 && ic_v) || (s.lock_for == 2'd2 && dc_v)) begin
      n.owner = s.lock_for;
      n.lock_for = 2'd0;
    end else begin
      n.lock_for = 2'd0;
      pick = 2'd0;
      if (ic_v && dc_v) begin
        pick = (fp || !s.last_dc) ? 2'd2 : 2'd1;
        n.ncf = (s.ncf + 32'd1) & mask;
      end else if (ic_v) pick = 2'd1;
      else if (dc_v) pick = 2'd2;
      if (pick == 2'd1) begin
        n.nic = (s.nic + 32'd1) & mask;
        n.last_dc = 1'b0;
      end
      if (pick == 2'd2) begin
        n.ndc = (s.ndc + 32'd1) & mask;
        n.last_dc = 1'b1;
      end
      n.owner = pick;
    end
  endfunction

  task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_ni) begin
      ms0 = '0;
      ms1 = '0;
    end
    model_step(ms0, 1'b0, 32'hFFFF_FFFF, e0, n0);
    model_step(ms1, 1'b1, 32'h0000_000F, e1, n1);
    chk("mem0", 300'({mv0, mrw0, ma0, mdat0}), 300'({e0.mv, e0.mrw, e0.ma, e0.mdat}));
    chk("res0", 300'({ic_rr0, dc_rr0, ic_rd0, dc_rd0}), 300'({e0.icr, e0.dcr, e0.rdat, e0.rdat}));
    chk("gnt0", 300'(g0), 300'(e0.g));
    chk("cnt0", 300'({nic0, ndc0, ncf0}), 300'({e0.nic, e0.ndc, e0.ncf}));
    chk("mem1", 300'({mv1, mrw1, ma1, mdat1}), 300'({e1.mv, e1.mrw, e1.ma, e1.mdat}));
    chk("res1", 300'({ic_rr1, dc_rr1, ic_rd1, dc_rd1}), 300'({e1.icr, e1.dcr, e1.rdat, e1.rdat}));
    chk("gnt1", 300'(g1), 300'(e1.g));
    chk("cnt1", 300'({32'(nic1), 32'(ndc1), 32'(ncf1)}), 300'({e1.nic, e1.ndc, e1.ncf}));
    if (rst_ni) begin
      ms0 = n0;
      ms1 = n1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    ic_v = 1'b0; ic_rw = 1'b0; ic_a = '0; ic_d = '0;
    dc_v = 1'b0; dc_rw = 1'b0; dc_a = '0; dc_d = '0;
    mr = 1'b0; md = '0;
  endtask

  task automatic do_reset();
    tick();
    rst_ni = 1'b0;
    clr_inputs();
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [1:0] seq0 [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic icg, dcg;

  initial begin
    // Icache-only read, ready on the third grant cycle
    do_reset();
    neg();
    chk("rst_grant", 300'(g0), 300'(2'b00));
    chk("rst_mv", 300'(mv0), 300'(1'b0));
    chk("rst_cnt", 300'({nic0, ndc0, ncf0}), 300'(96'd0));
    tick();
    ic_v = 1'b1; ic_rw = 1'b0; ic_a = 32'h0000_1040;
    neg();
    chk("t1_pre_grant", 300'(g0), 300'(2'b00));
    tick();
    neg();
    chk("t1_grant", 300'(g0), 300'(2'b01));
    chk("t1_mv", 300'(mv0), 300'(1'b1));
    chk("t1_addr", 300'(ma0), 300'(32'h0000_1040));
    tick();
    tick();
    mr = 1'b1; md = {4{32'hA5A5_A5A5}};
    neg();
    chk("t1_ic_ready", 300'({ic_rr0, dc_rr0}), 300'(2'b10));
    chk("t1_ic_data", 300'(ic_rd0), 300'({4{32'hA5A5_A5A5}}));
    chk("t1_cnt_ic", 300'(nic0), 300'(32'd1));
    tick();
    mr = 1'b0; ic_v = 1'b0;
    neg();
    chk("t1_idle", 300'({g0, ic_rr0}), 300'(3'b000));

    // Simultaneous requests after reset
    do_reset();
    ic_v = 1'b1; dc_v = 1'b1; ic_a = 32'h100; dc_a = 32'h200;
    tick();
    mr = 1'b1;
    neg();
    chk("t2_dc_first", 300'({g0, ic_rr0, dc_rr0}), 300'(4'b1001));
    tick();
    dc_v = 1'b0; mr = 1'b0;
    neg();
    chk("t2_gap", 300'(g0), 300'(2'b00));
    tick();
    mr = 1'b1;
    neg();
    chk("t2_ic_second", 300'({g0, ic_rr0, dc_rr0}), 300'(4'b0110));
    tick();
    ic_v = 1'b0; mr = 1'b0;
    neg();
    chk("t2_counters", 300'({nic0, ndc0, ncf0}), 300'({32'd1, 32'd1, 32'd1}));

    // Dcache write-back then allocate, icache waiting
    do_reset();
    ic_v = 1'b1; ic_a = 32'h300; dc_v = 1'b1; dc_rw = 1'b1; dc_a = 32'h0000_2000; dc_d = rnd_line();
    tick();
    mr = 1'b1;
    neg();
    chk("t3_wb", 300'({g0, mrw0, ma0, dc_rr0}), 300'({2'b10, 1'b1, 32'h0000_2000, 1'b1}));
    tick();
    mr = 1'b0; dc_rw = 1'b0;
    neg();
    chk("t3_lock", 300'({g0, mv0}), 300'(3'b000));
    tick();
    mr = 1'b1;
    neg();
    chk("t3_alloc", 300'({g0, mrw0, dc_rr0, ic_rr0}), 300'(5'b10010));
    tick();
    mr = 1'b0; dc_v = 1'b0;
    neg();
    chk("t3_gap", 300'(g0), 300'(2'b00));
    tick();
    mr = 1'b1;
    neg();
    chk("t3_ic", 300'({g0, ic_rr0}), 300'(3'b011));
    chk("t3_counters", 300'({nic0, ndc0, ncf0}), 300'({32'd1, 32'd1, 32'd1}));
    tick();
    ic_v = 1'b0; mr = 1'b0;

    // Continuous contention: round-robin alternates, fixed priority keeps dcache
    do_reset();
    ic_v = 1'b1; dc_v = 1'b1; mr = 1'b1;
    neg();
    chk("t4_start", 300'(g0), 300'(2'b00));
    for (int k = 0; k < 5; k++) begin
      tick();
      neg();
      chk("t4_rr_grant", 300'(g0), 300'(seq0[k]));
      chk("t4_fp_grant", 300'(g1), 300'(2'b10));
      tick();
      neg();
      chk("t4_gap", 300'({g0, g1}), 300'(4'b0000));
    end
    chk("t4_rr_cnt", 300'({nic0, ndc0, ncf0}), 300'({32'd2, 32'd3, 32'd5}));
    chk("t4_fp_cnt", 300'({nic1, ndc1, ncf1}), 300'({4'd0, 4'd5, 4'd5}));
    tick();
    ic_v = 1'b0; dc_v = 1'b0; mr = 1'b0;

    // Icache aborts two cycles into its grant
    do_reset();
    ic_v = 1'b1; ic_a = 32'h440;
    tick();
    neg();
    chk("t5_grant", 300'({g0, mv0}), 300'(3'b011));
    tick();
    tick();
    ic_v = 1'b0;
    neg();
    chk("t5_abort", 300'({g0, mv0}), 300'(3'b010));
    tick();
    mr = 1'b1;
    neg();
    chk("t5_late_ready", 300'({g0, ic_rr0, dc_rr0}), 300'(4'b0000));
    tick();
    mr = 1'b0;

    // Asynchronous reset in the middle of a dcache grant
    do_reset();
    dc_v = 1'b1; dc_a = 32'h880;
    tick();
    neg();
    chk("t6_pre", 300'({g0, mv0, ndc0}), 300'({2'b10, 1'b1, 32'd1}));
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    mr = 1'b1;
    ic_v = 1'b1;
    #1;
    chk("t6_async", 300'({g0, mv0, dc_rr0, ndc0, nic0, ncf0}), 300'(0));
    tick();
    rst_ni = 1'b1;
    mr = 1'b0;
    tick();
    neg();
    chk("t6_after", 300'({g0, g1}), 300'(4'b1010));
    tick();
    clr_inputs();

    // Random traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      neg();
      icg = ic_rr0;
      dcg = dc_rr0;
      tick();
      rst_ni = (cyc != 2000);
      mr = ($urandom_range(0, 99) < 30);
      md = rnd_line();
      if (ic_v) begin
        if (icg) begin
          if ($urandom_range(0, 1) == 0) ic_v = 1'b0;
          else begin ic_rw = 1'($urandom_range(0, 1)); ic_a = $urandom; ic_d = rnd_line(); end
        end else if ($urandom_range(0, 99) < 3) ic_v = 1'b0;
        else if ($urandom_range(0, 99) < 5) ic_a = $urandom;
      end else if ($urandom_range(0, 99) < 40) begin
        ic_v = 1'b1; ic_rw = 1'($urandom_range(0, 1)); ic_a = $urandom; ic_d = rnd_line();
      end
      if (dc_v) begin
        if (dcg) begin
          if ($urandom_range(0, 1) == 0) dc_v = 1'b0;
          else begin dc_rw = 1'($urandom_range(0, 1)); dc_a = $urandom; dc_d = rnd_line(); end
        end else if ($urandom_range(0, 99) < 3) dc_v = 1'b0;
        else if ($urandom_range(0, 99) < 5) dc_d = rnd_line();
      end else if ($urandom_range(0, 99) < 40) begin
        dc_v = 1'b1; dc_rw = 1'($urandom_range(0, 1)); dc_a = $urandom; dc_d = rnd_line();
      end
    end
    tick();
    clr_inputs();
    neg();
    neg();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
